// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
// The stats_t record backs the counters enabled by FIFO_STREAM_READER_STATS_EN.
package fifo_pkg;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_BUF_DEPTH = 2;

  // Pointer width for a power-of-two buffer; never narrower than one bit.
  function automatic int ptr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef logic [$clog2(DEFAULT_BUF_DEPTH)-1:0] ptr_t;

  typedef struct packed {
    logic [31:0] words_out;
    logic [15:0] poll_miss;
  } stats_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready output stream seen by fifo_stream_reader.
// master = the reader block, slave = the FIFO/downstream environment.
interface fifo_stream_reader_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             fifo_rd_valid;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_rd_valid,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_rd_valid,
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/fifo_reader_buf.sv
// Prefetch storage: one synchronous write port, combinational read port.
// Contents are deliberately not reset; validity is tracked by the owner's count.
module fifo_reader_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO read port into a registered valid/ready stream via a small prefetch buffer.
// Optional saturating counters (words_out, poll_miss) are built when FIFO_STREAM_READER_STATS_EN is defined.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int BUF_DEPTH = DEFAULT_BUF_DEPTH,
  parameter int CNT_BITS  = $clog2(BUF_DEPTH + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic                i_flush,
  fifo_stream_reader_if.master bus,
  output logic [CNT_BITS-1:0] o_buf_count
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [31:0]         o_words_out,
  output logic [15:0]         o_poll_miss
`endif
);
  localparam int PTR_W = ptr_bits(BUF_DEPTH);
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(BUF_DEPTH);

  typedef logic [PTR_W-1:0] buf_ptr_t;

  buf_ptr_t            r_wr_ptr;
  buf_ptr_t            r_rd_ptr;
  logic [CNT_BITS-1:0] r_count;

  logic             w_rd_en;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_rdata;

  // Read request looks only at registered occupancy, never at out_ready.
  assign w_rd_en = i_rst_n && i_enable && !i_flush && (r_count < FULL_CNT);
  assign w_push  = w_rd_en && bus.fifo_rd_valid;
  assign w_pop   = (r_count != '0) && bus.out_ready && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + buf_ptr_t'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + buf_ptr_t'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_BITS'(1);
        2'b01:   r_count <= r_count - CNT_BITS'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  fifo_reader_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH),
    .AW    (PTR_W)
  ) u_buf (
    .i_clk   (i_clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.fifo_rd_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.out_valid  = (r_count != '0);
  assign bus.out_data   = w_rdata;
  assign o_buf_count    = r_count;

`ifdef FIFO_STREAM_READER_STATS_EN
  stats_t r_stats;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stats <= '0;
    end else if (i_flush) begin
      r_stats <= '0;
    end else begin
      if (w_pop && (r_stats.words_out != '1)) begin
        r_stats.words_out <= r_stats.words_out + 32'd1;
      end
      if (w_rd_en && !bus.fifo_rd_valid && (r_stats.poll_miss != '1)) begin
        r_stats.poll_miss <= r_stats.poll_miss + 16'd1;
      end
    end
  end

  assign o_words_out = r_stats.words_out;
  assign o_poll_miss = r_stats.poll_miss;
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: directed vector table, hand sequences, random vs queue model.
// Stats checks are compiled in when FIFO_STREAM_READER_STATS_EN is defined.
module tb_fifo_stream_reader;
  localparam int W = 32;
  localparam int D = 2;
  localparam int CB = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          fl = 1'b0;
  logic [CB-1:0] cnt;
`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0]   wo;
  logic [15:0]   pm;
`endif

  always #5 clk = ~clk;

  fifo_stream_reader_if #(.WIDTH(W)) bus ();

  fifo_stream_reader #(
    .WIDTH     (W),
    .BUF_DEPTH (D)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_enable    (en),
    .i_flush     (fl),
    .bus         (bus),
    .o_buf_count (cnt)
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    .o_words_out (wo),
    .o_poll_miss (pm)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Behavioural model: buffer contents as a queue, FIFO contents as a queue.
  logic [31:0] mq[$];
  logic [31:0] src[$];
  logic [31:0] got[$];
  longint      m_wo = 0;
  int          m_pm = 0;

  task automatic step(input bit e, input bit f, input bit r, input string tag);
    bit          fv;
    bit          x_en;
    logic [31:0] fd;
    @(negedge clk);
    fv = (src.size() > 0);
    fd = fv ? src[0] : 32'hDEAD_BEEF;
    en = e;
    fl = f;
    bus.out_ready     = r;
    bus.fifo_rd_valid = fv;
    bus.fifo_rd_data  = fd;
    x_en = e && !f && (mq.size() < D);
    #1;
    chk({tag, " rd_en"}, 32'(bus.fifo_rd_en), 32'(x_en));
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(mq.size() != 0));
    chk({tag, " buf_count"}, 32'(cnt), 32'(mq.size()));
    if (mq.size() != 0) chk({tag, " out_data"}, bus.out_data, mq[0]);
`ifdef FIFO_STREAM_READER_STATS_EN
    chk({tag, " words_out"}, wo, 32'(m_wo));
    chk({tag, " poll_miss"}, 32'(pm), 32'(m_pm));
`endif
    if (f) begin
      mq.delete();
      m_wo = 0;
      m_pm = 0;
    end else begin
      if (mq.size() != 0 && r) begin
        got.push_back(mq[0]);
        void'(mq.pop_front());
        if (m_wo < 64'hFFFF_FFFF) m_wo++;
      end
      if (x_en && fv) mq.push_back(fd);
      if (x_en && !fv && m_pm < 65535) m_pm++;
    end
    if (x_en && fv) void'(src.pop_front());
  endtask

  typedef struct {
    bit          en, fl, rdy, fv;
    logic [31:0] fd;
    bit          x_rden, x_ov;
    int          x_cnt;
    logic [31:0] x_od, x_wo, x_pm;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int steps;
    tbl[0]  = '{1,0,1,0, 32'h0,        1,0,0, 32'h0,        0,0};
    tbl[1]  = '{1,0,1,0, 32'h0,        1,0,0, 32'h0,        0,1};
    tbl[2]  = '{1,0,1,0, 32'h0,        1,0,0, 32'h0,        0,2};
    tbl[3]  = '{1,0,1,0, 32'h0,        1,0,0, 32'h0,        0,3};
    tbl[4]  = '{1,0,1,1, 32'hA5A50001, 1,0,0, 32'h0,        0,4};
    tbl[5]  = '{0,0,1,0, 32'h0,        0,1,1, 32'hA5A50001, 0,4};
    tbl[6]  = '{0,0,0,0, 32'h0,        0,0,0, 32'h0,        1,4};
    tbl[7]  = '{1,0,0,1, 32'h11,       1,0,0, 32'h0,        1,4};
    tbl[8]  = '{1,0,0,1, 32'h22,       1,1,1, 32'h11,       1,4};
    tbl[9]  = '{1,0,0,1, 32'h33,       0,1,2, 32'h11,       1,4};
    tbl[10] = '{1,0,1,1, 32'h33,       0,1,2, 32'h11,       1,4};
    tbl[11] = '{1,0,1,1, 32'h33,       1,1,1, 32'h22,       2,4};
    tbl[12] = '{1,0,1,0, 32'h0,        1,1,1, 32'h33,       3,4};
    tbl[13] = '{0,0,1,0, 32'h0,        0,0,0, 32'h0,        4,5};
    tbl[14] = '{1,0,0,1, 32'h44,       1,0,0, 32'h0,        4,5};
    tbl[15] = '{1,0,0,1, 32'h55,       1,1,1, 32'h44,       4,5};
    tbl[16] = '{1,1,1,1, 32'h66,       0,1,2, 32'h44,       4,5};
    tbl[17] = '{0,0,1,0, 32'h0,        0,0,0, 32'h0,        0,0};

    // Reset state, with enable held high to show the read request stays low.
    en = 1'b1;
    bus.out_ready = 1'b0;
    bus.fifo_rd_valid = 1'b0;
    bus.fifo_rd_data = '0;
    @(negedge clk);
    #1;
    chk("reset rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset buf_count", 32'(cnt), 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      en = tbl[i].en;
      fl = tbl[i].fl;
      bus.out_ready = tbl[i].rdy;
      bus.fifo_rd_valid = tbl[i].fv;
      bus.fifo_rd_data = tbl[i].fd;
      #1;
      $display("vec %0d: rd_en=%0b out_valid=%0b buf_count=%0d out_data=0x%08h",
               i, bus.fifo_rd_en, bus.out_valid, cnt, bus.out_data);
      chk($sformatf("vec%0d rd_en", i), 32'(bus.fifo_rd_en), 32'(tbl[i].x_rden));
      chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(tbl[i].x_ov));
      chk($sformatf("vec%0d buf_count", i), 32'(cnt), 32'(tbl[i].x_cnt));
      if (tbl[i].x_ov) chk($sformatf("vec%0d out_data", i), bus.out_data, tbl[i].x_od);
`ifdef FIFO_STREAM_READER_STATS_EN
      chk($sformatf("vec%0d words_out", i), wo, tbl[i].x_wo);
      chk($sformatf("vec%0d poll_miss", i), 32'(pm), tbl[i].x_pm);
`endif
    end

    // Full buffer with continuous supply: every word once, in order, no gap.
    for (int k = 0; k < 6; k++) src.push_back(32'h100 + 32'(k));
    got.delete();
    step(1, 0, 0, "fill0");
    step(1, 0, 0, "fill1");
    steps = 0;
    while (got.size() < 6 && steps < 20) begin
      step(1, 0, 1, "stream");
      steps++;
    end
    chk("stream words", 32'(got.size()), 32'd6);
    chk("stream cycles", 32'(steps), 32'd6);
    for (int k = 0; k < got.size(); k++) begin
      $display("stream out %0d: 0x%08h", k, got[k]);
      chk($sformatf("stream order%0d", k), got[k], 32'h100 + 32'(k));
    end

    // Asynchronous reset while one word is buffered.
    src.push_back(32'h77);
    step(1, 0, 0, "pre_rst");
    @(negedge clk);
    en = 1'b0;
    bus.out_ready = 1'b0;
    bus.fifo_rd_valid = 1'b0;
    #1;
    chk("pre_rst buf_count", 32'(cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst buf_count", 32'(cnt), 32'd0);
`ifdef FIFO_STREAM_READER_STATS_EN
    chk("async_rst words_out", wo, 32'd0);
`endif
    mq.delete();
    src.delete();
    m_wo = 0;
    m_pm = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the queue model.
    got.delete();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) src.push_back($urandom);
      step($urandom_range(0, 5) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) != 0, "rand");
    end
    $display("random: %0d words delivered", got.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side consumer for the team's synchronous FIFO.
- Drains the FIFO read port (rd_en / rd_data / rd_valid) into a registered ready/valid output stream, using a small prefetch buffer.
- Decouples downstream backpressure from the FIFO pop timing. There is no combinational path from out_ready to fifo_rd_en.
- Sits between the FIFO and any downstream stage that needs a standard valid/ready handshake.

Parameters:
- WIDTH, 32, data word width; must match the FIFO WIDTH.
- BUF_DEPTH, 2, prefetch buffer entries; power of 2, at least 2.
- CNT_BITS, $clog2(BUF_DEPTH+1), width of buf_count (derived; do not override).

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- enable  input  1  allows issuing FIFO reads when 1.
- flush  input  1  synchronous discard of all buffered words.
- fifo_rd_en  output  1  FIFO read request.
- fifo_rd_data  input  WIDTH  FIFO read data; valid in the same cycle as fifo_rd_valid.
- fifo_rd_valid  input  1  FIFO asserts this in the same cycle as fifo_rd_en when non-empty; the pop takes effect at that posedge.
- out_valid  output  1  output word available.
- out_data  output  WIDTH  output word; held stable while out_valid && !out_ready.
- out_ready  input  1  downstream accepts the word.
- buf_count  output  CNT_BITS  number of occupied buffer entries.

Behaviour:
- Reset (reset==0, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - out_valid=0, fifo_rd_en=0, buf_count=0.
  - out_data is don't-care but must not be X-propagating into control logic.
  - Buffer storage is not reset.
- fifo_rd_en = enable && !flush && (count < BUF_DEPTH).
  - This depends on registered count plus the enable and flush inputs only; it never depends on out_ready.
- push = fifo_rd_en && fifo_rd_valid. On push, buf[wr_ptr] <= fifo_rd_data and wr_ptr increments, wrapping modulo BUF_DEPTH.
- fifo_rd_en && !fifo_rd_valid (FIFO empty) counts as a poll: no push, no state change.
- pop = out_valid && out_ready && !flush. On pop, rd_ptr increments with the same wrap rule.
- out_valid = (count != 0); out_data = buf[rd_ptr]. Both are driven from registers and pointer-muxed storage.
- Latency: a word popped from the FIFO at edge N appears on out_valid/out_data after edge N, i.e. one cycle minimum.
- Count update per cycle:
  - push && pop: unchanged.
  - push only: +1.
  - pop only: -1.
  - count never exceeds BUF_DEPTH and never underflows.
- Full buffer (count==BUF_DEPTH): fifo_rd_en=0, even if out_ready is 1 in that cycle. Reads resume the next cycle after a pop.
- Flush (priority over everything):
  - At the next edge, count, wr_ptr and rd_ptr go to 0.
  - No push or pop occurs in the flush cycle; out_valid drops the next cycle.
  - The FIFO itself is not flushed by this block.
- enable=0: no new reads are issued; buffered words continue draining to the output.
- Mid-operation async reset: the buffer empties immediately. Words already popped from the FIFO are lost; this is documented and accepted.
- Ordering: output order equals FIFO pop order, with no duplication and no loss except on flush or reset.

Optional Feature:
- Macro: FIFO_STREAM_READER_STATS_EN.
- When defined, two extra outputs are added:
  - words_out [31:0]: increments on each pop.
  - poll_miss [15:0]: increments on each fifo_rd_en && !fifo_rd_valid.
  - Both saturate at their maximum, reset to 0, and are cleared by flush.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package fifo_pkg:
  - DEFAULT_WIDTH.
  - A ptr_t typedef parameterised via $clog2(BUF_DEPTH).
  - A stats_t struct {words_out, poll_miss} used under the macro.
- One natural sub-module, fifo_reader_buf: the BUF_DEPTH×WIDTH storage array with write port (we, waddr, wdata) and combinational read (raddr, rdata). Pointer and count control stay in the top level.

Test Plan:
- Reset then enable=1 with FIFO empty (fifo_rd_valid=0), 4 cycles -> fifo_rd_en=1 every cycle, out_valid=0, buf_count=0; with stats, poll_miss=4.
- FIFO supplies 0xA5A5_0001 with out_ready=1 -> out_valid=1 and out_data=0xA5A5_0001 one cycle later; buf_count returns to 0 after the handshake.
- out_ready=0, FIFO supplies 0x11, 0x22, 0x33 -> buf_count reaches 2 and fifo_rd_en drops; 0x33 stays in the FIFO. Raise out_ready -> output 0x11, 0x22, 0x33 in order.
- Buffer full with out_ready=1 for 6 cycles and a continuous FIFO supply of 0x100..0x105 -> every word is output once, in order, with no gap after the first fill.
- Buffer holding 2 words, assert flush for 1 cycle -> next cycle out_valid=0, buf_count=0, and fifo_rd_en=0 during the flush cycle.
- Drop reset while buf_count=1 -> out_valid=0 and buf_count=0 asynchronously, before the next clock edge.
